// File: rtl/vsb_writeback_stage.sv
// vsb_writeback_stage
// Writeback stage of the value-similarity pipeline. Keeps one VSB entry
// {valid, tag, vec} per pointer register, filled by line-aligned LOAD hits
// and looked up by PTRINC. It emits a registered pointer-similarity write
// to the register file and a registered reference-element status write.
// Reference-buffer writes go through a small FIFO with a valid/ready
// handshake. The instruction side is back-pressured while that FIFO is full.
//
// Optional build macro: VSB_WB_STATS_EN adds StatHitOut/StatMissOut, which
// are saturating 16-bit PTRINC match/miss counters cleared by FlushIn.
//
// Opcode values are parameters, so the decoder can follow the ISA encoding
// without edits to this file.
module vsb_writeback_stage #(
  parameter int          NUM_PTR    = 4,
  parameter int          LINE_WORDS = 8,
  parameter int          RB_DEPTH   = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [6:0]  OP_LOAD    = 7'b0000011,
  parameter logic [6:0]  OP_PTRINC  = 7'b0010011,
  parameter logic [6:0]  OP_COMPUTE = 7'b0110011,
  localparam int         OFS        = $clog2(LINE_WORDS) + 2,
  localparam int         RBW        = $clog2(RB_DEPTH),
  localparam int         PW         = $clog2(NUM_PTR)
) (
  input  logic                  ClockIn,
  input  logic                  AsyncResetIn,
  input  logic                  WbValidIn,
  output logic                  WbReadyOut,
  input  logic [31:0]           InstructionIn,
  input  logic [31:0]           WbDataIn,
  input  logic                  CacheHitIn,
  input  logic [31:0]           CacheAddrIn,
  input  logic [LINE_WORDS-2:0] VSByIn,
  input  logic                  IsRefElemIn,
  input  logic [RBW-1:0]        RbIdxIn,
  input  logic [PW-1:0]         PtrRegIdIn,
  input  logic                  FlushIn,
  output logic                  RfPtrSimWrOut,
  output logic                  RfPtrSimBitOut,
  output logic [4:0]            RfPtrRegIdxOut,
  output logic                  RbWrValidOut,
  input  logic                  RbWrReadyIn,
  output logic                  RbWrValidBitOut,
  output logic [RBW-1:0]        RbWrIdxOut,
  output logic [PW-1:0]         RbWrPtrRegIdOut,
  output logic [31:0]           RbWrDataOut,
  output logic                  RefElemWrEnOut,
  output logic                  RefElemWrFlagOut,
  output logic [RBW-1:0]        RefElemWrIdxOut
`ifdef VSB_WB_STATS_EN
  ,
  output logic [15:0]           StatHitOut,
  output logic [15:0]           StatMissOut
`endif
);

  localparam int TAGW = 32 - OFS;
  localparam int WW   = OFS - 2;
  localparam int FAW  = $clog2(FIFO_DEPTH);
  localparam int FCW  = FAW + 1;
  localparam int EW   = 1 + RBW + PW + 32;

  // ---------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [PW-1:0]   ld_idx;
  logic [PW-1:0]   pi_idx;
  logic            accept;
  logic            is_load;
  logic            is_ptrinc;
  logic            is_compute;

  assign opcode     = InstructionIn[31:25];
  assign rd         = InstructionIn[24:20];
  assign ld_idx     = InstructionIn[15 +: PW];
  assign pi_idx     = rd[PW-1:0];
  assign accept     = WbValidIn && WbReadyOut;
  assign is_load    = accept && (opcode == OP_LOAD);
  assign is_ptrinc  = accept && (opcode == OP_PTRINC);
  assign is_compute = accept && (opcode == OP_COMPUTE);

  // Only the pointer-table index bits of rs are meaningful here.
  logic unused_bits;
  assign unused_bits = ^{InstructionIn[19:15], InstructionIn[14:0]};

  // ---------------------------------------------------------------------
  // VSB table
  // ---------------------------------------------------------------------
  logic                  valid_q [NUM_PTR];
  logic [TAGW-1:0]       tag_q   [NUM_PTR];
  logic [LINE_WORDS-1:0] vec_q   [NUM_PTR];

  logic            ld_aligned;
  logic            tbl_wr;
  logic [TAGW-1:0] pi_tag;
  logic [WW-1:0]   pi_word;
  logic            pi_aligned;
  logic            pi_match;

  assign ld_aligned = (CacheAddrIn[OFS-1:0] == '0);
  assign tbl_wr     = is_load && CacheHitIn && ld_aligned;
  assign pi_tag     = WbDataIn[31:OFS];
  assign pi_word    = WbDataIn[OFS-1:2];
  assign pi_aligned = (WbDataIn[OFS-1:0] == '0);
  assign pi_match   = valid_q[pi_idx] && (tag_q[pi_idx] == pi_tag);

  // Table update: flush wins over a same-cycle LOAD fill. Word 0 of a line is
  // always similar to the line base, hence the constant 1 in the vector.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      for (int i = 0; i < NUM_PTR; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        vec_q[i]   <= '0;
      end
    end else if (FlushIn) begin
      for (int i = 0; i < NUM_PTR; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (tbl_wr) begin
      valid_q[ld_idx] <= 1'b1;
      tag_q[ld_idx]   <= CacheAddrIn[31:OFS];
      vec_q[ld_idx]   <= {VSByIn, 1'b1};
    end
  end

  // ---------------------------------------------------------------------
  // Similarity and reference-element strobes
  // ---------------------------------------------------------------------
  logic sim_wr;
  logic sim_bit;

  // A line-aligned pointer is trivially "not similar"; otherwise the bit comes
  // from the matching entry, and a miss produces no write at all.
  always_comb begin
    sim_wr  = 1'b0;
    sim_bit = 1'b0;
    if (is_ptrinc) begin
      if (pi_aligned) begin
        sim_wr  = 1'b1;
        sim_bit = 1'b0;
      end else if (pi_match) begin
        sim_wr  = 1'b1;
        sim_bit = vec_q[pi_idx][pi_word];
      end
    end
  end

  // Registered one-cycle strobes; payload fields are zeroed when idle.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      RfPtrSimWrOut    <= 1'b0;
      RfPtrSimBitOut   <= 1'b0;
      RfPtrRegIdxOut   <= '0;
      RefElemWrEnOut   <= 1'b0;
      RefElemWrFlagOut <= 1'b0;
      RefElemWrIdxOut  <= '0;
    end else begin
      RfPtrSimWrOut    <= sim_wr;
      RfPtrSimBitOut   <= sim_wr && sim_bit;
      RfPtrRegIdxOut   <= sim_wr ? rd : 5'd0;
      RefElemWrEnOut   <= is_load;
      RefElemWrFlagOut <= is_load && ld_aligned;
      RefElemWrIdxOut  <= is_load ? RbIdxIn : '0;
    end
  end

  // ---------------------------------------------------------------------
  // RB write FIFO
  // ---------------------------------------------------------------------
  logic            push;
  logic [EW-1:0]   push_entry;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]  wr_ptr;
  logic [FAW-1:0]  rd_ptr;
  logic [FCW-1:0]  count;
  logic [EW-1:0]   head;

  // Entry layout: {valid bit, RB index, pointer register id, data}. A PTRINC
  // miss sends an invalidate for the pointer register's RB slot.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (is_load && ld_aligned) begin
      push       = 1'b1;
      push_entry = {1'b1, RbIdxIn, PtrRegIdIn, WbDataIn};
    end else if (is_ptrinc && !pi_match) begin
      push       = 1'b1;
      push_entry = {1'b0, {RBW{1'b0}}, pi_idx, 32'h0};
    end else if (is_compute && IsRefElemIn) begin
      push       = 1'b1;
      push_entry = {1'b1, RbIdxIn, {PW{1'b0}}, WbDataIn};
    end
  end

  assign fifo_full  = (count == FCW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && RbWrReadyIn;

  // Pointer and occupancy bookkeeping; a push can only occur when not full.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: everything read from it is masked while empty.
  always_ff @(posedge ClockIn) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  assign head         = fifo_mem[rd_ptr];
  assign RbWrValidOut = !fifo_empty;
  assign {RbWrValidBitOut, RbWrIdxOut, RbWrPtrRegIdOut, RbWrDataOut} =
    fifo_empty ? '0 : head;

  // Ready is forced low while reset is asserted so every output reads 0.
  assign WbReadyOut = AsyncResetIn && !fifo_full;

`ifdef VSB_WB_STATS_EN
  // ---------------------------------------------------------------------
  // Saturating PTRINC match / miss counters
  // ---------------------------------------------------------------------
  logic stat_hit_inc;
  logic stat_miss_inc;

  assign stat_hit_inc  = is_ptrinc && pi_match;
  assign stat_miss_inc = is_ptrinc && !pi_match && !pi_aligned;

  // Flush clears the counters and takes priority over a same-cycle count.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      StatHitOut  <= '0;
      StatMissOut <= '0;
    end else if (FlushIn) begin
      StatHitOut  <= '0;
      StatMissOut <= '0;
    end else begin
      if (stat_hit_inc && (StatHitOut != 16'hFFFF))
        StatHitOut <= StatHitOut + 1'b1;
      if (stat_miss_inc && (StatMissOut != 16'hFFFF))
        StatMissOut <= StatMissOut + 1'b1;
    end
  end
`endif

endmodule

// File: doc/vsb_writeback_stage.md
# vsb_writeback_stage

Parametrised writeback stage for the value-similarity pipeline. It holds a per-pointer-register VSB (value-similarity bit) table and generates registered pointer-similarity writes to the register file and reference-element status updates. Reference-buffer (RB) writes pass through an internal FIFO with a valid/ready handshake. It sits between the MEM stage/cache and the register file, RB and instruction-status table, with a configurable table depth and line size.

## Interface
- NUM_PTR, default 4: VSB table entries, one per pointer register; power of two, 2..16.
- LINE_WORDS, default 8: 32-bit words per cache line; power of two, 4..16. OFS = log2(LINE_WORDS)+2.
- RB_DEPTH, default 16: RB entries; RBW = log2(RB_DEPTH).
- FIFO_DEPTH, default 4: RB write queue depth; power of two, ≥2.
- ClockIn, input, 1: clock, rising edge.
- AsyncResetIn, input, 1: reset, asynchronous, active-low.
- WbValidIn / WbReadyOut, input / output, 1 each: instruction handshake. Accept = both high.
- InstructionIn, input, 32: opcode [31:25], rd [24:20], rs [19:15].
- WbDataIn, input, 32: writeback data or pointer value.
- CacheHitIn, input, 1: cache hit. CacheAddrIn, input, 32: cache address.
- VSByIn, input, LINE_WORDS-1: similarity bits for words 1..LINE_WORDS-1.
- IsRefElemIn, input, 1: COMPUTE result is a reference element.
- RbIdxIn, input, RBW: RB index. PtrRegIdIn, input, log2(NUM_PTR): pointer register id.
- FlushIn, input, 1: invalidate all VSB entries.
- RfPtrSimWrOut / RfPtrSimBitOut, output, 1 each: RF pointer-similarity write strobe and bit. RfPtrRegIdxOut, output, 5: register index.
- RbWrValidOut, output, 1; RbWrReadyIn, input, 1: RB write handshake.
- RbWrValidBitOut, output, 1: RB valid bit. RbWrIdxOut, output, RBW. RbWrPtrRegIdOut, output, log2(NUM_PTR). RbWrDataOut, output, 32.
- RefElemWrEnOut / RefElemWrFlagOut, output, 1 each; RefElemWrIdxOut, output, RBW: instruction-status write.

## Operation
- WbReadyOut = !fifo_full. An instruction is processed only on accept. With no accept, all strobes are 0 on the next cycle.
- VSB entry: {valid, tag[31:OFS], vec[LINE_WORDS-1:0]}.
- LOAD: idx = rs mod NUM_PTR.
  - If CacheHitIn and CacheAddrIn[OFS-1:0]==0: entry <= {1, CacheAddrIn[31:OFS], {VSByIn,1'b1}}.
  - On every LOAD, a RefElem write: flag = (offset==0), idx = RbIdxIn.
  - If offset==0, push RB write {valid=1, RbIdxIn, PtrRegIdIn, WbDataIn}.
- PTRINC: idx = rd mod NUM_PTR, word = WbDataIn[OFS-1:2], match = valid && tag==WbDataIn[31:OFS].
  - If WbDataIn[OFS-1:0]==0: sim write bit 0 to rd.
  - Else if match: sim write vec[word] to rd.
  - Else: no sim write.
  - If !match: push RB invalidate {valid=0, idx 0, PtrRegId = rd mod NUM_PTR, data 0}.
- COMPUTE with IsRefElemIn: push {valid=1, RbIdxIn, PtrRegId 0, WbDataIn}.
- Other opcodes: no effect.
- FlushIn clears all valid bits. It overrides a same-cycle LOAD table update.
- FIFO:
  - Push on accept when a push is required. Pop when RbWrValidOut && RbWrReadyIn.
  - Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
  - The head entry is held stable while RbWrReadyIn is low.

## Timing
- Sim and RefElem outputs are registered: valid 1 cycle after accept, 1-cycle pulse.
- A table write is visible to the PTRINC accepted on the next cycle (no same-cycle bypass needed, one instruction per cycle).
- An RB push appears on RbWrValidOut 1 cycle after accept if the FIFO was empty.
- Full: WbReadyOut drops in the same cycle the count reaches FIFO_DEPTH. It rises the cycle after a pop.
- Reset (async assert, any time):
  - All outputs are 0, with WbReadyOut = 1 after deassertion.
  - Table valid, tag and vec are 0. FIFO is empty. Mid-flight FIFO contents are dropped.

## Configuration
- VSB_WB_STATS_EN defined:
  - Adds outputs StatHitOut and StatMissOut, 16 bits each.
  - Counts PTRINC with match / with !match and nonzero offset.
  - Saturating at 0xFFFF; reset to 0; cleared by FlushIn.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- LOAD rs=1, hit, CacheAddrIn=0x1000, VSByIn=7'b1010101 → entry1 = {1, tag 0x1000>>5, vec 0xAB}. PTRINC rd=1, WbDataIn=0x1004 → next cycle sim wr=1, bit=1, idx=1. WbDataIn=0x1008 → bit=0.
- PTRINC rd=2, WbDataIn=0x2000 → sim wr=1, bit=0, idx=2. An RB invalidate is pushed (valid bit 0, PtrRegId 2) because the entry is invalid.
- RbWrReadyIn=0, 4 RB-pushing instructions → WbReadyOut=0 after the 4th. Raise ready → 4 pops in order, WbReadyOut=1 one cycle after the first pop.
- LOAD with FlushIn=1 same cycle → entry stays invalid. Subsequent PTRINC same line → no sim write, RB invalidate pushed.
- COMPUTE, IsRefElemIn=1, RbIdxIn=5, WbDataIn=0xDEAD → RB write {1, 5, 0, 0xDEAD}. LOAD at offset 0x04 → RefElem wr=1, flag=0.
- Assert AsyncResetIn low with 3 FIFO entries pending and a PTRINC accepted → all outputs 0 immediately, FIFO empty, table cleared. With stats enabled, counters are 0.
